vseg_capture: RTL and testbench
===============================

VSEG_CAPTURE -- requirements
Module: vseg_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYC, default 4, giving the consecutive identical samples needed to accept a digit (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port seg_L, input, 7 bits: observed cathodes, active low, bit order {g,f,e,d,c,b,a}.
REQ-005 The block SHALL have port anode_L, input, 4 bits: observed digit enables, active low, bit i = digit i.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of captured state.
REQ-007 The block SHALL have port digits, output, 16 bits: captured hex values, digit i in bits [4i+3:4i].
REQ-008 The block SHALL have port dig_valid, output, 4 bits: bit i is 1 when digit i holds an accepted non-blank value.
REQ-009 The block SHALL have port upd, output, 1 bit: one-cycle pulse on each acceptance.
REQ-010 The block SHALL have port upd_idx, output, 2 bits: index of the digit accepted, valid while upd = 1.
REQ-011 The block SHALL have port err, output, 1 bit: sticky flag for an undecodable pattern.

Function
REQ-012 seg_L and anode_L SHALL pass through a 2-flop synchronizer before any use, and sample k SHALL denote the synchronized value after edge k.
REQ-013 A sample SHALL be qualified only when exactly one anode_L bit is 0; zero or multiple low bits SHALL be unqualified and SHALL reset the stability counter to 0.
REQ-014 An 8-bit stability counter SHALL increment, saturating, while consecutive qualified samples are identical in {anode_L,seg_L}, and SHALL restart at 1 on any change.
REQ-015 Acceptance SHALL occur exactly once, on the sample where the counter reaches STABLE_CYC, and SHALL NOT repeat while the counter is saturated.
REQ-016 Inputs held constant from edge 1 SHALL produce upd = 1 and updated digits and dig_valid after edge STABLE_CYC+2.
REQ-017 Decoding SHALL use active-high pattern p = ~seg_L with the table 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71 (hex).
REQ-018 On acceptance of a table pattern, the block SHALL write the digit field, set dig_valid[i], and pulse upd with upd_idx = i.
REQ-019 On acceptance of p = 00 (blank), the block SHALL clear dig_valid[i], leave the digit field unchanged, and pulse upd.
REQ-020 On acceptance of any other pattern, the block SHALL set err, clear dig_valid[i], leave the digit field unchanged, and SHALL NOT pulse upd.
REQ-021 clr = 1 SHALL zero digits, dig_valid, err and upd on the next edge; clr SHALL win over a simultaneous acceptance, and the stability counter SHALL be unaffected.
REQ-022 Digits not currently being driven SHALL retain their captured value.

Reset
REQ-023 rst_L = 0 SHALL immediately force digits = 0000, dig_valid = 0, upd = 0, upd_idx = 0, err = 0, stability counter = 0 and the synchronizer flops to all-ones (idle display).
REQ-024 A reset asserted mid-count SHALL abandon the pending acceptance, and after release the count SHALL restart from 0.

Configuration
REQ-025 With macro VSEG_CAPTURE_ERR_EN defined, REQ-020 SHALL apply; without it, err SHALL be tied 0 and a non-table pattern SHALL be treated as blank per REQ-019.

Verification
REQ-026 anode_L = 1110, seg_L = ~7D held 10 cycles, STABLE_CYC = 4 -> upd pulse after edge 6, upd_idx = 0, digits[3:0] = 6, dig_valid = 0001.
REQ-027 Digit 0 = ~06 for 6 cycles, then anode_L = 1101, seg_L = ~71 for 6 cycles -> digits = 00F1, dig_valid = 0011, exactly two upd pulses.
REQ-028 anode_L = 1110, seg_L = ~4F held 3 cycles then toggled to ~5B -> no upd until ~5B has been stable for 4 samples, then digits[3:0] = 2.
REQ-029 anode_L = 1100 or 1111 held 20 cycles -> no upd and outputs unchanged.
REQ-030 With VSEG_CAPTURE_ERR_EN defined, seg_L = ~01 stable on digit 1 -> err = 1 and dig_valid[1] = 0; then clr pulse -> err = 0, digits = 0000.
REQ-031 rst_L asserted for 1 cycle at stability count 3, then a stable ~7F -> upd occurs STABLE_CYC+2 edges after release, digits[3:0] = 8.

Source files
------------

// File: rtl/vseg_capture.sv
// -----------------------------------------------------------------------------
// vseg_capture
// Observes a multiplexed, active-low 4-digit 7-segment display bus and
// recovers the hex value shown on each digit. A digit is accepted once the
// same {anode, segment} pattern has been seen on STABLE_CYC consecutive
// qualified samples (exactly one anode enabled).
//
// Optional feature: define VSEG_CAPTURE_ERR_EN to flag undecodable segment
// patterns on err. Without it, err is tied 0 and such patterns act as blank.
//
// Ports:
//   clk        rising-edge clock
//   rst_L      asynchronous active-low reset
//   seg_L      observed cathodes, active low, {g,f,e,d,c,b,a}
//   anode_L    observed digit enables, active low, bit i = digit i
//   clr        synchronous clear of captured digits/valid/err/upd
//   digits     captured hex values, digit i in [4i+3:4i]
//   dig_valid  digit i holds an accepted non-blank value
//   upd        one-cycle pulse per acceptance
//   upd_idx    index of the accepted digit, valid while upd = 1
//   err        sticky undecodable-pattern flag
// -----------------------------------------------------------------------------
module vseg_capture #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [6:0]  seg_L,
    input  logic [3:0]  anode_L,
    input  logic        clr,
    output logic [15:0] digits,
    output logic [3:0]  dig_valid,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        err
);

`ifdef VSEG_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Acceptance fires on the sample that moves the count from STABLE_CYC-1
    // to STABLE_CYC, so a saturated counter never re-triggers.
    localparam logic [7:0] ACC_PREV = 8'(STABLE_CYC - 1);

    logic [6:0]  seg_meta_reg, seg_sync_reg;
    logic [3:0]  an_meta_reg, an_sync_reg;
    logic [10:0] samp_prev_reg;
    logic [7:0]  cnt_reg, cnt_next;
    logic        upd_reg, upd_next;
    logic [1:0]  upd_idx_reg;

    logic [3:0]  an_act;
    logic        qualified, same;
    logic        accept;
    logic [1:0]  acc_idx;
    logic [6:0]  pat;
    logic [3:0]  hex_val;
    logic        hex_hit, blank;

    // Synchronizers idle at all-ones (display dark), matching the reset value
    // of the previous-sample register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            seg_meta_reg  <= '1;
            seg_sync_reg  <= '1;
            an_meta_reg   <= '1;
            an_sync_reg   <= '1;
            samp_prev_reg <= '1;
            cnt_reg       <= '0;
        end else begin
            seg_meta_reg  <= seg_L;
            seg_sync_reg  <= seg_meta_reg;
            an_meta_reg   <= anode_L;
            an_sync_reg   <= an_meta_reg;
            samp_prev_reg <= {an_sync_reg, seg_sync_reg};
            cnt_reg       <= cnt_next;
        end
    end

    assign an_act    = ~an_sync_reg;
    assign qualified = (an_act != 4'd0) && ((an_act & (an_act - 4'd1)) == 4'd0);
    // A zero count means the previous sample was unqualified, so it never
    // counts as a continuation even if the bits happen to match.
    assign same      = (cnt_reg != 8'd0) && ({an_sync_reg, seg_sync_reg} == samp_prev_reg);

    always_comb begin
        cnt_next = 8'd0;
        if (qualified) begin
            if (!same)
                cnt_next = 8'd1;
            else if (cnt_reg != 8'hFF)
                cnt_next = cnt_reg + 8'd1;
            else
                cnt_next = cnt_reg;
        end
    end

    assign accept = qualified && same && (cnt_reg == ACC_PREV);

    always_comb begin
        acc_idx = 2'd0;
        case (an_act)
            4'b0010: acc_idx = 2'd1;
            4'b0100: acc_idx = 2'd2;
            4'b1000: acc_idx = 2'd3;
            default: acc_idx = 2'd0;
        endcase
    end

    assign pat   = ~seg_sync_reg;
    assign blank = (pat == 7'h00);

    always_comb begin
        hex_hit = 1'b1;
        hex_val = 4'h0;
        case (pat)
            7'h3F: hex_val = 4'h0;
            7'h06: hex_val = 4'h1;
            7'h5B: hex_val = 4'h2;
            7'h4F: hex_val = 4'h3;
            7'h66: hex_val = 4'h4;
            7'h6D: hex_val = 4'h5;
            7'h7D: hex_val = 4'h6;
            7'h07: hex_val = 4'h7;
            7'h7F: hex_val = 4'h8;
            7'h6F: hex_val = 4'h9;
            7'h77: hex_val = 4'hA;
            7'h7C: hex_val = 4'hB;
            7'h39: hex_val = 4'hC;
            7'h5E: hex_val = 4'hD;
            7'h79: hex_val = 4'hE;
            7'h71: hex_val = 4'hF;
            default: hex_hit = 1'b0;
        endcase
    end

    // Undecodable patterns only suppress the pulse when they are being flagged.
    assign upd_next = accept && (hex_hit || blank || !ERR_EN);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            upd_reg     <= 1'b0;
            upd_idx_reg <= 2'd0;
        end else if (clr) begin
            upd_reg     <= 1'b0;
        end else begin
            upd_reg <= upd_next;
            if (accept)
                upd_idx_reg <= acc_idx;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] val_reg;
            logic       vld_reg;
            always_ff @(posedge clk or negedge rst_L) begin
                if (!rst_L) begin
                    val_reg <= 4'h0;
                    vld_reg <= 1'b0;
                end else if (clr) begin
                    val_reg <= 4'h0;
                    vld_reg <= 1'b0;
                end else if (accept && (acc_idx == 2'(gi))) begin
                    // Blank and undecodable patterns keep the old value but
                    // mark the digit as not holding anything.
                    if (hex_hit)
                        val_reg <= hex_val;
                    vld_reg <= hex_hit;
                end
            end
            assign digits[4*gi +: 4] = val_reg;
            assign dig_valid[gi]     = vld_reg;
        end
    endgenerate

`ifdef VSEG_CAPTURE_ERR_EN
    logic err_reg;
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)
            err_reg <= 1'b0;
        else if (clr)
            err_reg <= 1'b0;
        else if (accept && !hex_hit && !blank)
            err_reg <= 1'b1;
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign upd     = upd_reg;
    assign upd_idx = upd_idx_reg;

endmodule

// File: tb/tb_vseg_capture.sv
// -----------------------------------------------------------------------------
// tb_vseg_capture
// Directed bench for vseg_capture (STABLE_CYC = 4). A table of held display
// patterns checks captured state and pulse counts; hand-written sequences
// check exact acceptance timing, reset mid-count and clr priority.
// -----------------------------------------------------------------------------
module tb_vseg_capture;

`ifdef VSEG_CAPTURE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_L;
    logic [6:0]  seg_L;
    logic [3:0]  anode_L;
    logic        clr;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;

    int checks = 0;
    int errors = 0;

    vseg_capture #(.STABLE_CYC(4)) dut (
        .clk      (clk),
        .rst_L    (rst_L),
        .seg_L    (seg_L),
        .anode_L  (anode_L),
        .clr      (clr),
        .digits   (digits),
        .dig_valid(dig_valid),
        .upd      (upd),
        .upd_idx  (upd_idx),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  pat;      // active-high pattern; driven as ~pat
        int          cyc;
        int          exp_upd;
        logic [1:0]  exp_idx;
        logic [15:0] exp_dig;
        logic [3:0]  exp_val;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    int       upd_cnt;
    logic [1:0] last_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply a pattern and run n edges, counting upd pulses.
    task automatic hold(input logic [3:0] an, input logic [6:0] pat, input int n);
        anode_L = an;
        seg_L   = ~pat;
        upd_cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (upd === 1'b1) begin
                upd_cnt++;
                last_idx = upd_idx;
            end
        end
    endtask

    initial begin
        vecs[0] = '{4'b1110, 7'h7D, 10, 1, 2'd0, 16'h0006, 4'b0001, 1'b0};
        vecs[1] = '{4'b1110, 7'h06, 10, 1, 2'd0, 16'h0001, 4'b0001, 1'b0};
        vecs[2] = '{4'b1101, 7'h71, 10, 1, 2'd1, 16'h00F1, 4'b0011, 1'b0};
        vecs[3] = '{4'b1100, 7'h7F, 20, 0, 2'd1, 16'h00F1, 4'b0011, 1'b0};
        vecs[4] = '{4'b1111, 7'h7F, 20, 0, 2'd1, 16'h00F1, 4'b0011, 1'b0};
        vecs[5] = '{4'b0111, 7'h5E, 10, 1, 2'd3, 16'hD0F1, 4'b1011, 1'b0};
        vecs[6] = '{4'b1110, 7'h00, 10, 1, 2'd0, 16'hD0F1, 4'b1010, 1'b0};
        vecs[7] = '{4'b1101, 7'h01, 10, ERR_EN ? 0 : 1, ERR_EN ? 2'd0 : 2'd1,
                    16'hD0F1, 4'b1000, ERR_EN};
        vecs[8] = '{4'b1011, 7'h77, 10, 1, 2'd2, 16'hDAF1, 4'b1100, ERR_EN};

        rst_L = 1'b0; clr = 1'b0; anode_L = 4'hF; seg_L = 7'h7F;
        last_idx = 2'd0;
        #1;
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_valid",  32'(dig_valid), 32'h0);
        chk("reset_upd",    32'(upd), 32'h0);
        chk("reset_idx",    32'(upd_idx), 32'h0);
        chk("reset_err",    32'(err), 32'h0);
        @(posedge clk); #1;
        rst_L = 1'b1;

        for (int v = 0; v < 9; v++) begin
            hold(vecs[v].an, vecs[v].pat, vecs[v].cyc);
            $display("vec %0d an=%b pat=%h upd=%0d digits=%h valid=%b err=%b",
                     v, vecs[v].an, vecs[v].pat, upd_cnt, digits, dig_valid, err);
            chk($sformatf("vec%0d_upd", v),    32'(upd_cnt), 32'(vecs[v].exp_upd));
            if (vecs[v].exp_upd > 0)
                chk($sformatf("vec%0d_idx", v), 32'(last_idx), 32'(vecs[v].exp_idx));
            chk($sformatf("vec%0d_digits", v), 32'(digits), 32'(vecs[v].exp_dig));
            chk($sformatf("vec%0d_valid", v),  32'(dig_valid), 32'(vecs[v].exp_val));
            chk($sformatf("vec%0d_err", v),    32'(err), 32'(vecs[v].exp_err));
        end

        // clr clears captured state and the sticky error.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        $display("clr digits=%h valid=%b err=%b", digits, dig_valid, err);
        chk("clr_digits", 32'(digits), 32'h0);
        chk("clr_valid",  32'(dig_valid), 32'h0);
        chk("clr_err",    32'(err), 32'h0);

        // Exact acceptance edge: upd only after edge STABLE_CYC+2 = 6.
        anode_L = 4'b1110; seg_L = ~7'h7D;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("timing_upd_e%0d", k), 32'(upd), 32'(k == 6));
            if (k == 6) begin
                chk("timing_idx",    32'(upd_idx), 32'd0);
                chk("timing_digits", 32'(digits), 32'h0006);
                chk("timing_valid",  32'(dig_valid), 32'b0001);
            end
        end
        $display("timing seq digits=%h valid=%b", digits, dig_valid);

        // Short-lived 3 then 2: only the 2 is accepted, 6 edges after the toggle.
        hold(4'b1110, 7'h4F, 3);
        chk("toggle_no_early_upd", 32'(upd_cnt), 32'd0);
        seg_L = ~7'h5B;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("toggle_upd_e%0d", k), 32'(upd), 32'(k == 6));
        end
        $display("toggle seq digits=%h valid=%b", digits, dig_valid);
        chk("toggle_digits", 32'(digits), 32'h0002);

        // Reset at count 3 abandons the pending 8; it is re-accepted later.
        hold(4'b1110, 7'h7F, 5);
        chk("rstmid_no_upd", 32'(upd_cnt), 32'd0);
        rst_L = 1'b0;
        #1;
        chk("rstmid_async_digits", 32'(digits), 32'h0);
        chk("rstmid_async_valid",  32'(dig_valid), 32'h0);
        @(posedge clk); #1;
        rst_L = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rstmid_upd_e%0d", k), 32'(upd), 32'(k == 6));
        end
        $display("reset seq digits=%h valid=%b", digits, dig_valid);
        chk("rstmid_digits", 32'(digits), 32'h0008);

        // clr on the acceptance edge wins; the counter is not disturbed, so
        // the pattern is not accepted again afterwards.
        hold(4'b1101, 7'h66, 5);
        chk("clrwin_no_early_upd", 32'(upd_cnt), 32'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clrwin_upd",    32'(upd), 32'd0);
        chk("clrwin_digits", 32'(digits), 32'h0);
        chk("clrwin_valid",  32'(dig_valid), 32'h0);
        hold(4'b1101, 7'h66, 8);
        $display("clr-win seq upd=%0d digits=%h valid=%b", upd_cnt, digits, dig_valid);
        chk("clrwin_no_reaccept", 32'(upd_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
